// File: rtl/heap_move_long_pkg.sv
// rtl/heap_move_long_pkg.sv - FSM/direction types and heap address helper for heap_move_long
package heap_move_long_pkg;

    typedef enum logic [2:0] {IDLE, CHECK, FILL, STREAM, DRAIN, DONE} state_e;

    typedef enum logic {DIR_ASC, DIR_DESC} dir_e;

    function automatic logic [31:0] heapAddr(input int array, input int offset, input int n_area);
        return 32'(n_area * array + offset);
    endfunction

endpackage

// File: rtl/heap_move_long_agu.sv
// rtl/heap_move_long_agu.sv - address generator: read index, one-cycle-delayed write index, last-read flag
module heap_move_long_agu
    import heap_move_long_pkg::*;
#(
    parameter int HA = 7,
    parameter int OW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic          step,
    input  logic [HA:0]   srcBase,
    input  logic [HA:0]   tgtBase,
    input  logic [OW-1:0] len,
    input  dir_e          dir,
    output logic [HA-1:0] rdAddr,
    output logic [HA-1:0] wrAddr,
    output logic          last
);

    logic [HA:0]   src_q;
    logic [HA:0]   tgt_q;
    logic [OW-1:0] rd_idx;
    logic [OW-1:0] wr_idx;
    logic [OW-1:0] cnt;
    dir_e          dir_q;
    logic [HA:0]   rd_sum;
    logic [HA:0]   wr_sum;

    always_ff @(posedge clock) begin
        if (reset) begin
            src_q  <= '0;
            tgt_q  <= '0;
            rd_idx <= '0;
            wr_idx <= '0;
            cnt    <= '0;
            dir_q  <= DIR_ASC;
        end else if (load) begin
            src_q  <= srcBase;
            tgt_q  <= tgtBase;
            dir_q  <= dir;
            rd_idx <= (dir == DIR_DESC) ? len - OW'(1) : '0;
            wr_idx <= '0;
            cnt    <= len - OW'(1);
        end else if (step) begin
            // the element read this cycle is the one written next cycle
            wr_idx <= rd_idx;
            if (cnt != '0) begin
                rd_idx <= (dir_q == DIR_DESC) ? rd_idx - OW'(1) : rd_idx + OW'(1);
                cnt    <= cnt - OW'(1);
            end
        end
    end

    assign rd_sum = src_q + (HA+1)'(rd_idx);
    assign wr_sum = tgt_q + (HA+1)'(wr_idx);
    assign rdAddr = rd_sum[HA-1:0];
    assign wrAddr = wr_sum[HA-1:0];
    assign last   = (cnt == '0);

endmodule

// File: rtl/heap_move_long.sv
// rtl/heap_move_long.sv - overlap-safe heap block-copy engine; HEAP_MOVE_LONG_BOUNDS_EN rejects out-of-bounds requests
module heap_move_long
    import heap_move_long_pkg::*;
#(
    parameter int MemoryElementWidth = 12,
    parameter int NArea              = 10,
    parameter int NArrays            = 20,
    parameter int NHeap              = 100,
    localparam int AI = $clog2(NArrays),
    localparam int HA = $clog2(NHeap),
    localparam int OW = $clog2(NArea + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [AI-1:0]                 srcArray,
    input  logic [OW-1:0]                 srcOffset,
    input  logic [AI-1:0]                 tgtArray,
    input  logic [OW-1:0]                 tgtOffset,
    input  logic [OW-1:0]                 length,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic                          memRdEn,
    output logic [HA-1:0]                 memRdAddr,
    input  logic [MemoryElementWidth-1:0] memRdData,
    output logic                          memWrEn,
    output logic [HA-1:0]                 memWrAddr,
    output logic [MemoryElementWidth-1:0] memWrData
);

    state_e        state;
    state_e        state_nxt;
    logic [AI-1:0] src_arr_q;
    logic [AI-1:0] tgt_arr_q;
    logic [OW-1:0] src_off_q;
    logic [OW-1:0] tgt_off_q;
    logic [OW-1:0] len_q;
    logic          err_q;

    logic [31:0]   src_full;
    logic [31:0]   tgt_full;
    logic [HA:0]   src_base;
    logic [HA:0]   tgt_base;
    logic [HA+1:0] src_limit;
    logic [OW-1:0] mv_len;
    logic          bad;
    dir_e          dir;

    logic          agu_load;
    logic          agu_step;
    logic          agu_last;
    logic [HA-1:0] agu_rd_addr;
    logic [HA-1:0] agu_wr_addr;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            src_arr_q <= '0;
            tgt_arr_q <= '0;
            src_off_q <= '0;
            tgt_off_q <= '0;
            len_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                src_arr_q <= srcArray;
                tgt_arr_q <= tgtArray;
                src_off_q <= srcOffset;
                tgt_off_q <= tgtOffset;
                len_q     <= length;
            end
            if (state == CHECK) begin
                err_q <= bad;
            end
        end
    end

`ifdef HEAP_MOVE_LONG_BOUNDS_EN
    logic [OW:0] src_end;
    logic [OW:0] tgt_end;

    always_comb begin
        src_end = {1'b0, src_off_q} + {1'b0, len_q};
        tgt_end = {1'b0, tgt_off_q} + {1'b0, len_q};
        bad     = (int'(src_end) > NArea) || (int'(tgt_end) > NArea) ||
                  (int'(src_arr_q) >= NArrays) || (int'(tgt_arr_q) >= NArrays);
        mv_len  = len_q;
    end
`else
    localparam logic [OW:0] AREA_W = (OW+1)'(NArea);
    logic [OW:0] src_room;
    logic [OW:0] tgt_room;
    logic [OW:0] clamp_len;

    // copy only the part that stays inside both areas
    always_comb begin
        src_room  = (int'(src_off_q) >= NArea) ? '0 : AREA_W - {1'b0, src_off_q};
        tgt_room  = (int'(tgt_off_q) >= NArea) ? '0 : AREA_W - {1'b0, tgt_off_q};
        clamp_len = {1'b0, len_q};
        if (src_room < clamp_len) clamp_len = src_room;
        if (tgt_room < clamp_len) clamp_len = tgt_room;
        bad       = 1'b0;
        mv_len    = clamp_len[OW-1:0];
    end
`endif

    always_comb begin
        src_full  = heapAddr(int'(src_arr_q), int'(src_off_q), NArea);
        tgt_full  = heapAddr(int'(tgt_arr_q), int'(tgt_off_q), NArea);
        src_base  = src_full[HA:0];
        tgt_base  = tgt_full[HA:0];
        src_limit = {1'b0, src_base} + (HA+2)'(mv_len);
        // target starting inside the source run must be copied back to front
        dir       = (({1'b0, tgt_base} > {1'b0, src_base}) && ({1'b0, tgt_base} < src_limit))
                    ? DIR_DESC : DIR_ASC;
    end

    always_comb begin
        state_nxt = state;
        agu_load  = 1'b0;
        agu_step  = 1'b0;
        memRdEn   = 1'b0;
        memWrEn   = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = CHECK;
            CHECK: begin
                if (bad || mv_len == '0) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = FILL;
                    agu_load  = 1'b1;
                end
            end
            FILL: begin
                memRdEn   = 1'b1;
                agu_step  = 1'b1;
                state_nxt = agu_last ? DRAIN : STREAM;
            end
            STREAM: begin
                memRdEn   = 1'b1;
                memWrEn   = 1'b1;
                agu_step  = 1'b1;
                state_nxt = agu_last ? DRAIN : STREAM;
            end
            DRAIN: begin
                memWrEn   = 1'b1;
                state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    heap_move_long_agu #(
        .HA (HA),
        .OW (OW)
    ) u_agu (
        .clock   (clock),
        .reset   (reset),
        .load    (agu_load),
        .step    (agu_step),
        .srcBase (src_base),
        .tgtBase (tgt_base),
        .len     (mv_len),
        .dir     (dir),
        .rdAddr  (agu_rd_addr),
        .wrAddr  (agu_wr_addr),
        .last    (agu_last)
    );

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign error     = (state == DONE) && err_q;
    assign memRdAddr = memRdEn ? agu_rd_addr : '0;
    assign memWrAddr = memWrEn ? agu_wr_addr : '0;
    assign memWrData = memWrEn ? memRdData : '0;

endmodule

// File: tb/tb_heap_move_long.sv
// tb/tb_heap_move_long.sv - randomized self-checking bench for heap_move_long against a memmove heap model
`timescale 1ns/1ps
module tb_heap_move_long;

    localparam int MEW   = 12;
    localparam int NAREA = 10;
    localparam int NARR  = 20;
    localparam int AI    = 5;
    localparam int HA    = 7;
    localparam int OW    = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic           start;
    logic [AI-1:0]  srcArray;
    logic [OW-1:0]  srcOffset;
    logic [AI-1:0]  tgtArray;
    logic [OW-1:0]  tgtOffset;
    logic [OW-1:0]  length;
    logic           busy;
    logic           done;
    logic           error;
    logic           memRdEn;
    logic [HA-1:0]  memRdAddr;
    logic [MEW-1:0] memRdData = '0;
    logic           memWrEn;
    logic [HA-1:0]  memWrAddr;
    logic [MEW-1:0] memWrData;

    logic [MEW-1:0] heap     [0:127];
    logic [MEW-1:0] ref_heap [0:127];

    int n_cmp = 0;
    int n_err = 0;
    int rd_total = 0;
    int wr_total = 0;
    int coll_total = 0;
    int done_total = 0;

    always #5 clock = ~clock;

    heap_move_long dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .srcArray  (srcArray),
        .srcOffset (srcOffset),
        .tgtArray  (tgtArray),
        .tgtOffset (tgtOffset),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .memRdEn   (memRdEn),
        .memRdAddr (memRdAddr),
        .memRdData (memRdData),
        .memWrEn   (memWrEn),
        .memWrAddr (memWrAddr),
        .memWrData (memWrData)
    );

    // 1-cycle-latency synchronous heap RAM plus activity counters
    always @(posedge clock) begin
        if (memRdEn) begin
            memRdData <= heap[memRdAddr];
            rd_total  <= rd_total + 1;
        end
        if (memWrEn) begin
            heap[memWrAddr] <= memWrData;
            wr_total        <= wr_total + 1;
        end
        if (memRdEn && memWrEn && memRdAddr == memWrAddr) coll_total <= coll_total + 1;
        if (done) done_total <= done_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit rejected(input int sa, input int so, input int ta, input int to, input int ln);
`ifdef HEAP_MOVE_LONG_BOUNDS_EN
        return (so + ln > NAREA) || (to + ln > NAREA) || (sa >= NARR) || (ta >= NARR);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int moved_count(input int sa, input int so, input int ta, input int to, input int ln);
        int e;
`ifdef HEAP_MOVE_LONG_BOUNDS_EN
        e = rejected(sa, so, ta, to, ln) ? 0 : ln;
`else
        e = ln;
        if (NAREA - so < e) e = NAREA - so;
        if (NAREA - to < e) e = NAREA - to;
        if (e < 0) e = 0;
`endif
        return e;
    endfunction

    task automatic ref_move(input int sa, input int so, input int ta, input int to, input int n);
        logic [MEW-1:0] tmp [$];
        for (int i = 0; i < n; i++) tmp.push_back(ref_heap[sa*NAREA + so + i]);
        for (int i = 0; i < n; i++) ref_heap[ta*NAREA + to + i] = tmp[i];
    endtask

    task automatic fill_heap();
        logic [MEW-1:0] v;
        for (int i = 0; i < 128; i++) begin
            v = MEW'($urandom);
            if (i < NAREA) v = MEW'(i);
            else if (i < 2*NAREA) v = MEW'(100 + i - NAREA);
            heap[i]     = v;
            ref_heap[i] = v;
        end
    endtask

    task automatic check_heap(input string tag);
        int nbad = 0;
        for (int i = 0; i < 100; i++) if (heap[i] !== ref_heap[i]) nbad++;
        check({tag, "_heap"}, nbad, 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic do_move(input string tag, input int sa, input int so, input int ta, input int to, input int ln);
        int  n;
        int  mv;
        int  lat_exp;
        int  rd0;
        int  wr0;
        int  co0;
        int  nbusy;
        bit  got;
        bit  rej;
        logic err_seen;
        rej      = rejected(sa, so, ta, to, ln);
        mv       = moved_count(sa, so, ta, to, ln);
        lat_exp  = (mv == 0) ? 2 : mv + 3;
        err_seen = 1'b0;
        @(negedge clock);
        srcArray  = AI'(sa);
        srcOffset = OW'(so);
        tgtArray  = AI'(ta);
        tgtOffset = OW'(to);
        length    = OW'(ln);
        start     = 1'b1;
        rd0 = rd_total;
        wr0 = wr_total;
        co0 = coll_total;
        @(posedge clock);
        n = 0;
        got = 1'b0;
        nbusy = 0;
        while (!got && n < 60) begin
            @(negedge clock);
            n++;
            if (!busy) nbusy++;
            if (done) begin
                got      = 1'b1;
                err_seen = error;
                start    = 1'b0;
            end else begin
                start     = 1'($urandom_range(0, 1));
                srcArray  = AI'($urandom);
                srcOffset = OW'($urandom);
                tgtArray  = AI'($urandom);
                tgtOffset = OW'($urandom);
                length    = OW'($urandom);
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, got ? n : 0, lat_exp);
        check({tag, "_error"}, err_seen, rej);
        check({tag, "_busy_during"}, nbusy, 0);
        @(negedge clock);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_busy_after"}, busy, 0);
        ref_move(sa, so, ta, to, mv);
        check({tag, "_reads"}, rd_total - rd0, mv);
        check({tag, "_writes"}, wr_total - wr0, mv);
        check({tag, "_collide"}, coll_total - co0, 0);
        check_heap(tag);
        if (!got) do_reset();
    endtask

    initial begin
        int exp2 [10];
        int exp3 [10];
        int wr0;
        int wr1;
        int dn0;
        int sa;
        int ta;

        reset = 1'b1;
        start = 1'b0;
        srcArray = '0; srcOffset = '0; tgtArray = '0; tgtOffset = '0; length = '0;
        fill_heap();
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_rden", memRdEn, 0);
        check("rst_wren", memWrEn, 0);
        check("rst_rdaddr", memRdAddr, 0);
        check("rst_wraddr", memWrAddr, 0);
        check("rst_wrdata", memWrData, 0);
        reset = 1'b0;

        fill_heap();
        do_move("t1", 0, 4, 1, 2, 3);
        for (int i = 0; i < NAREA; i++)
            check("t1_area1", heap[NAREA + i], (i >= 2 && i <= 4) ? i + 2 : 100 + i);

        fill_heap();
        exp2 = '{0, 1, 0, 1, 2, 3, 4, 7, 8, 9};
        do_move("t2", 0, 0, 0, 2, 5);
        for (int i = 0; i < NAREA; i++) check("t2_area0", heap[i], exp2[i]);

        fill_heap();
        exp3 = '{0, 3, 4, 5, 6, 5, 6, 7, 8, 9};
        do_move("t3", 0, 3, 0, 1, 4);
        for (int i = 0; i < NAREA; i++) check("t3_area0", heap[i], exp3[i]);

        fill_heap();
        do_move("t4", 2, 1, 3, 5, 0);

        fill_heap();
        do_move("t5", 0, 8, 1, 0, 5);
`ifdef HEAP_MOVE_LONG_BOUNDS_EN
        check("t5_a1_0", heap[NAREA], 100);
        check("t5_a1_1", heap[NAREA + 1], 101);
`else
        check("t5_a1_0", heap[NAREA], 8);
        check("t5_a1_1", heap[NAREA + 1], 9);
`endif
        check("t5_a1_2", heap[NAREA + 2], 102);

        fill_heap();
        do_move("same", 4, 3, 4, 3, 6);

        for (int k = 0; k < 40; k++) begin
            sa = $urandom_range(0, 9);
            ta = ($urandom_range(0, 2) == 0) ? sa : $urandom_range(0, 9);
            if (k % 5 == 0) fill_heap();
            do_move("rnd", sa, $urandom_range(0, 12), ta, $urandom_range(0, 12), $urandom_range(0, 12));
        end

        // abort two cycles into STREAM of a 10-element copy
        fill_heap();
        @(negedge clock);
        srcArray = 5'd2; srcOffset = '0; tgtArray = 5'd3; tgtOffset = '0; length = 4'd10;
        start = 1'b1;
        wr0 = wr_total;
        @(posedge clock);
        repeat (3) begin
            @(negedge clock);
            start = 1'b0;
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_wren", memWrEn, 0);
        check("t6_writes_before", wr_total - wr0, 2);
        wr1 = wr_total;
        dn0 = done_total;
        repeat (20) @(negedge clock);
        check("t6_writes_after", wr_total - wr1, 0);
        check("t6_done", done_total - dn0, 0);
        ref_move(2, 0, 3, 0, 2);
        check_heap("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
